// File: rtl/fb_stream_pkg.sv
// fb_stream_pkg: shared types and constants for the frame-buffer stream source.
// Optional build macro used by this block: FB_STREAM_TESTPAT_EN (colour-bar generator).
package fb_stream_pkg;

    localparam int PIX_W = 12;
    localparam int CH_W  = 10;

    // Luma-style weights for gray, sum of weights = 256.
    localparam logic [7:0] GRAY_WR = 8'd77;
    localparam logic [7:0] GRAY_WG = 8'd150;
    localparam logic [7:0] GRAY_WB = 8'd29;

    // Warm tint weights for pink.
    localparam logic [7:0] PINK_WR = 8'd120;
    localparam logic [7:0] PINK_WG = 8'd60;
    localparam logic [7:0] PINK_WB = 8'd50;

    localparam logic [CH_W-1:0] CH_FULL = 10'h3FC;

    typedef enum logic [1:0] {
        FILT_COLOUR  = 2'd0,
        FILT_PINK    = 2'd1,
        FILT_GRAY    = 2'd2,
        FILT_TESTPAT = 2'd3
    } filter_e;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [3*CH_W-1:0] data;
    } pixel_beat_t;

    // Menu code to filter; unused codes fall back to plain colour.
    function automatic filter_e decode_filter(input logic [2:0] sel);
        filter_e f;
        case (sel)
            3'd1:    f = FILT_PINK;
            3'd2:    f = FILT_GRAY;
            3'd3:    f = FILT_TESTPAT;
            default: f = FILT_COLOUR;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/pixel_filter.sv
// pixel_filter: one registered stage that expands RGB444 to 10-bit channels and
// applies the frame's colour filter. Sideband SOP/EOP ride along with the pixel.
// FB_STREAM_TESTPAT_EN adds the 8-bar test pattern on FILT_TESTPAT; without it
// that code is plain colour and no bar logic exists.
module pixel_filter
    import fb_stream_pkg::*;
#(
    parameter int H_RES = 320,
    parameter int COL_W = $clog2(H_RES)
) (
    input  logic             clk,
    input  logic             clear_i,
    input  logic             vld_i,
    input  logic             sop_i,
    input  logic             eop_i,
    input  filter_e          filt_i,
    input  logic [COL_W-1:0] col_i,
    input  logic [PIX_W-1:0] pix_i,
    output logic             vld_o,
    output pixel_beat_t      beat_o
);

    logic [CH_W-1:0]   r_c, g_c, b_c;
    logic [17:0]       gray_sum, pink_sum;
    logic [CH_W-1:0]   gray_v, pink_v;
    logic [3*CH_W-1:0] data_d;
    logic              vld_q;
    pixel_beat_t       beat_q;

    // Channel expansion and weighted sums; 1020*256 still fits in 18 bits.
    always_comb begin
        r_c      = {pix_i[11:8], pix_i[11:8], 2'b00};
        g_c      = {pix_i[7:4],  pix_i[7:4],  2'b00};
        b_c      = {pix_i[3:0],  pix_i[3:0],  2'b00};
        gray_sum = 18'(r_c) * 18'(GRAY_WR) + 18'(g_c) * 18'(GRAY_WG) + 18'(b_c) * 18'(GRAY_WB);
        pink_sum = 18'(r_c) * 18'(PINK_WR) + 18'(g_c) * 18'(PINK_WG) + 18'(b_c) * 18'(PINK_WB);
        gray_v   = gray_sum[17:8];
        pink_v   = pink_sum[17:8];
    end

`ifdef FB_STREAM_TESTPAT_EN
    logic [2:0] bar_idx;
    logic [2:0] bar_rgb;

    // Bar index from column, then {R,G,B} on/off for white..black.
    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (32'(col_i) >= 32'(i * (H_RES / 8))) bar_idx = 3'(i);
        end
        case (bar_idx)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
    end
`else
    logic unused_col;
    assign unused_col = ^col_i;
`endif

    // Filter select.
    always_comb begin
        case (filt_i)
            FILT_PINK: data_d = {pink_v, 2'b00, pink_v[CH_W-1:2], 1'b0, pink_v[CH_W-1:1]};
            FILT_GRAY: data_d = {3{gray_v}};
`ifdef FB_STREAM_TESTPAT_EN
            FILT_TESTPAT: data_d = {bar_rgb[2] ? CH_FULL : {CH_W{1'b0}},
                                    bar_rgb[1] ? CH_FULL : {CH_W{1'b0}},
                                    bar_rgb[0] ? CH_FULL : {CH_W{1'b0}}};
`endif
            default:   data_d = {r_c, g_c, b_c};
        endcase
    end

    // Output register; clear drops the beat so a flush empties this stage too.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            vld_q  <= 1'b0;
            beat_q <= '0;
        end else begin
            vld_q <= vld_i;
            if (vld_i) begin
                beat_q.sop  <= sop_i;
                beat_q.eop  <= eop_i;
                beat_q.data <= data_d;
            end
        end
    end

    assign vld_o  = vld_q;
    assign beat_o = beat_q;

endmodule

// File: rtl/fb_stream_source.sv
// fb_stream_source: raster-order frame-buffer reader emitting an Avalon-ST video
// packet. Reads are only issued when the output FIFO has room for every beat
// still in the RAM/filter pipe, so backpressure never drops or repeats a pixel.
// Build macro FB_STREAM_TESTPAT_EN enables the colour-bar test pattern (sel 3).
module fb_stream_source
    import fb_stream_pkg::*;
#(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_restart,
    input  logic [2:0]        filter_sel,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic [3*CH_W-1:0] src_data,
    output logic              src_sop,
    output logic              src_eop,
    output logic              frame_done
);

    localparam int COL_W = $clog2(H_RES);
    localparam int ROW_W = $clog2(V_RES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              clear;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    filter_e           frame_filt_q, frame_filt_d, issue_filt;
    logic              issue, issue_sop, issue_eop;
    logic [CNT_W:0]    credit_used;

    logic              s1_vld_q, s1_sop_q, s1_eop_q;
    filter_e           s1_filt_q;
    logic [COL_W-1:0]  s1_col_q;
    logic              s2_vld;
    pixel_beat_t       s2_beat;

    pixel_beat_t       fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic              push, pop;
    pixel_beat_t       head;

    assign clear       = reset | frame_restart;
    assign credit_used = {1'b0, fifo_cnt_q} + {{(CNT_W-1){1'b0}}, s1_vld_q}
                                            + {{(CNT_W-1){1'b0}}, s2_vld};
    assign issue       = credit_used < (CNT_W+1)'(FIFO_DEPTH);
    assign issue_sop   = (col_q == '0) && (row_q == '0);
    assign issue_eop   = (col_q == COL_W'(H_RES-1)) && (row_q == ROW_W'(V_RES-1));

    // Raster counters; the address simply steps by one and wraps at end of frame.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        addr_d       = addr_q;
        frame_filt_d = frame_filt_q;
        issue_filt   = issue_sop ? decode_filter(filter_sel) : frame_filt_q;
        if (issue) begin
            if (issue_sop) frame_filt_d = decode_filter(filter_sel);
            if (col_q == COL_W'(H_RES-1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(V_RES-1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            addr_d = issue_eop ? '0 : addr_q + 1'b1;
        end
    end

    // Counter and frame-filter registers.
    always_ff @(posedge clk) begin
        if (clear) begin
            col_q        <= '0;
            row_q        <= '0;
            addr_q       <= '0;
            frame_filt_q <= FILT_COLOUR;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            addr_q       <= addr_d;
            frame_filt_q <= frame_filt_d;
        end
    end

    // RAM-stage sideband: tracks which cycles' rd_data belong to an issued read.
    always_ff @(posedge clk) begin
        if (clear) begin
            s1_vld_q  <= 1'b0;
            s1_sop_q  <= 1'b0;
            s1_eop_q  <= 1'b0;
            s1_filt_q <= FILT_COLOUR;
            s1_col_q  <= '0;
        end else begin
            s1_vld_q  <= issue;
            s1_sop_q  <= issue_sop;
            s1_eop_q  <= issue_eop;
            s1_filt_q <= issue_filt;
            s1_col_q  <= col_q;
        end
    end

    pixel_filter #(
        .H_RES (H_RES),
        .COL_W (COL_W)
    ) u_filter (
        .clk     (clk),
        .clear_i (clear),
        .vld_i   (s1_vld_q),
        .sop_i   (s1_sop_q),
        .eop_i   (s1_eop_q),
        .filt_i  (s1_filt_q),
        .col_i   (s1_col_q),
        .pix_i   (rd_data),
        .vld_o   (s2_vld),
        .beat_o  (s2_beat)
    );

    assign push = s2_vld;
    assign pop  = src_valid & src_ready;

    // FIFO occupancy next-state.
    always_comb begin
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // FIFO pointers and count.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // FIFO storage; stale entries are harmless because pointers reset on clear.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= s2_beat;
    end

    assign head       = fifo_mem_q[rd_ptr_q];
    assign src_valid  = (fifo_cnt_q != '0);
    assign src_data   = src_valid ? head.data : '0;
    assign src_sop    = src_valid & head.sop;
    assign src_eop    = src_valid & head.eop;
    assign frame_done = pop & head.eop;
    assign rd_addr    = addr_q;

endmodule

// File: tb/tb_fb_stream_source.sv
// tb_fb_stream_source: directed sequence with random backpressure and RAM
// contents, checked against a pixel-index reference model. A reduced frame
// size keeps the run short; the same rules apply at full size.
module tb_fb_stream_source;

    localparam int H    = 64;
    localparam int V    = 5;
    localparam int NPIX = H * V;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_restart;
    logic [2:0]  filter_sel;
    logic [16:0] rd_addr;
    logic [11:0] rd_data;
    logic        src_valid;
    logic        src_ready;
    logic [29:0] src_data;
    logic        src_sop;
    logic        src_eop;
    logic        frame_done;

    logic [11:0] ram [0:NPIX-1];

    int n_cmp = 0;
    int n_err = 0;
    int exp_idx = 0;
    int frame_filt = 0;
    int beats = 0;
    logic        stall_prev = 1'b0;
    logic [29:0] held_data;
    logic        held_sop, held_eop;

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= ram[int'(rd_addr) % NPIX];

    fb_stream_source #(
        .H_RES      (H),
        .V_RES      (V),
        .ADDR_W     (17),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_restart (frame_restart),
        .filter_sel    (filter_sel),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .src_data      (src_data),
        .src_sop       (src_sop),
        .src_eop       (src_eop),
        .frame_done    (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, want %0h (beat %0d)", tag, obs, exp, exp_idx);
        end
    endtask

    // 0 colour, 1 pink, 2 gray, 3 bars
    function automatic int sel_to_filt(input logic [2:0] s);
        if (s == 3'd1) return 1;
        if (s == 3'd2) return 2;
`ifdef FB_STREAM_TESTPAT_EN
        if (s == 3'd3) return 3;
`endif
        return 0;
    endfunction

    function automatic logic [29:0] model_px(input logic [11:0] pix, input int f, input int col);
        int r, g, b, y, p, bar;
        logic [2:0] m;
        r = int'(pix[11:8]) * 68;   // {n,n,00} == n*68
        g = int'(pix[7:4]) * 68;
        b = int'(pix[3:0]) * 68;
        case (f)
            1: begin
                p = (r * 120 + g * 60 + b * 50) / 256;
                return {10'(p), 10'(p / 4), 10'(p / 2)};
            end
            2: begin
                y = (r * 77 + g * 150 + b * 29) / 256;
                return {10'(y), 10'(y), 10'(y)};
            end
            3: begin
                bar = col / (H / 8);
                case (bar)
                    0: m = 3'b111;  // white
                    1: m = 3'b110;  // yellow
                    2: m = 3'b011;  // cyan
                    3: m = 3'b010;  // green
                    4: m = 3'b101;  // magenta
                    5: m = 3'b100;  // red
                    6: m = 3'b001;  // blue
                    default: m = 3'b000;  // black
                endcase
                return {m[2] ? 10'h3FC : 10'h0, m[1] ? 10'h3FC : 10'h0, m[0] ? 10'h3FC : 10'h0};
            end
            default: return {10'(r), 10'(g), 10'(b)};
        endcase
    endfunction

    // One cycle: drive ready, check hold-stability and any beat accepted at the coming edge.
    task automatic step(input int ready_pct);
        logic        acc;
        logic [29:0] exp;
        @(negedge clk);
        src_ready = ($urandom_range(0, 99) < ready_pct);
        #1;
        if (stall_prev) begin
            chk("hold_valid", 32'(src_valid), 32'd1);
            chk("hold_data",  32'(src_data),  32'(held_data));
            chk("hold_sop",   32'(src_sop),   32'(held_sop));
            chk("hold_eop",   32'(src_eop),   32'(held_eop));
        end
        acc = src_valid && src_ready;
        chk("frame_done", 32'(frame_done), 32'(acc && (exp_idx == NPIX - 1)));
        if (acc) begin
            if (exp_idx == 0) frame_filt = sel_to_filt(filter_sel);
            exp = model_px(ram[exp_idx], frame_filt, exp_idx % H);
            chk("data", 32'(src_data), 32'(exp));
            chk("sop",  32'(src_sop),  32'(exp_idx == 0));
            chk("eop",  32'(src_eop),  32'(exp_idx == NPIX - 1));
            if (exp_idx == 5 && frame_filt == 2) chk("gray_fff", 32'(src_data), 32'({10'd1020, 10'd1020, 10'd1020}));
            if (exp_idx == 6 && frame_filt == 2) chk("gray_f00", 32'(src_data), 32'({10'd306, 10'd306, 10'd306}));
            if (exp_idx == 5 && frame_filt == 1) chk("pink_fff", 32'(src_data), 32'({10'd916, 10'd229, 10'd458}));
            if (exp_idx == 6 && frame_filt == 1) chk("pink_f00", 32'(src_data), 32'({10'd478, 10'd119, 10'd239}));
            if (exp_idx == 5 && frame_filt == 0) chk("colour_fff", 32'(src_data), 32'({10'd1020, 10'd1020, 10'd1020}));
            if (exp_idx == 0 && frame_filt == 3) chk("bar_white", 32'(src_data), 32'({10'h3FC, 10'h3FC, 10'h3FC}));
            if (exp_idx == H - 1 && frame_filt == 3) chk("bar_black", 32'(src_data), 32'd0);
            exp_idx = (exp_idx == NPIX - 1) ? 0 : exp_idx + 1;
            beats++;
        end
        stall_prev = src_valid && !src_ready;
        held_data  = src_data;
        held_sop   = src_sop;
        held_eop   = src_eop;
    endtask

    task automatic run_beats(input int n, input int ready_pct);
        int target, guard;
        target = beats + n;
        guard  = 20 * n + 100;
        while (beats < target && guard > 0) begin
            step(ready_pct);
            guard--;
        end
        if (beats < target) begin
            n_cmp++;
            n_err++;
            $error("FAIL timeout_beats: got %0d beats, want %0d", beats, target);
        end
    endtask

    task automatic run_until_idx(input int t, input int ready_pct);
        int guard;
        guard = 40 * NPIX;
        while (exp_idx != t && guard > 0) begin
            step(ready_pct);
            guard--;
        end
        if (exp_idx != t) begin
            n_cmp++;
            n_err++;
            $error("FAIL timeout_idx: got %0d, want %0d", exp_idx, t);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(src_valid),  32'd0);
        chk({tag, "_data"},  32'(src_data),   32'd0);
        chk({tag, "_sop"},   32'(src_sop),    32'd0);
        chk({tag, "_eop"},   32'(src_eop),    32'd0);
        chk({tag, "_done"},  32'(frame_done), 32'd0);
        chk({tag, "_addr"},  32'(rd_addr),    32'd0);
    endtask

    initial begin
        int lat;
        logic [2:0] sel_list [5];
        sel_list = '{3'd2, 3'd1, 3'd3, 3'd5, 3'd0};
        for (int a = 0; a < NPIX; a++) ram[a] = 12'($urandom);
        ram[5] = 12'hFFF;
        ram[6] = 12'hF00;

        reset = 1'b1;
        frame_restart = 1'b0;
        filter_sel = 3'd0;
        src_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");

        // Release with ready low and measure latency to first valid.
        @(negedge clk);
        reset = 1'b0;
        src_ready = 1'b0;
        lat = 0;
        while (!src_valid && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        chk("first_valid_latency", 32'(lat), 32'd3);
        chk("first_sop", 32'(src_sop), 32'd1);

        // Full frame at full throughput, wrapping into the next frame.
        run_beats(NPIX + 2, 100);

        // Random backpressure with mid-frame filter changes.
        run_until_idx(100, 50);
        for (int k = 0; k < 5; k++) begin
            filter_sel = sel_list[k];
            run_beats(NPIX, 50);
        end

        // frame_restart with ready low mid-frame.
        run_until_idx(150, 50);
        @(negedge clk);
        src_ready = 1'b0;
        stall_prev = 1'b0;
        @(negedge clk);
        frame_restart = 1'b1;
        @(negedge clk);
        #1;
        chk_all_zero("restart");
        frame_restart = 1'b0;
        exp_idx = 0;
        run_beats(NPIX + 5, 75);

        // Reset together with frame_restart mid-frame.
        run_until_idx(200, 50);
        @(negedge clk);
        reset = 1'b1;
        frame_restart = 1'b1;
        src_ready = 1'b1;
        stall_prev = 1'b0;
        @(negedge clk);
        #1;
        chk_all_zero("midreset");
        reset = 1'b0;
        frame_restart = 1'b0;
        filter_sel = 3'd0;
        exp_idx = 0;
        run_until_idx(100, 100);
        filter_sel = 3'd3;
        run_beats(NPIX + 2, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
